// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// bnn_pkg : shared BNN constants, segment indices and loader state encoding
// Revision: 1.0
// ============================================================================
package bnn_pkg;

    localparam int W_ADDR_LEN_DEF = 20;
    localparam int X_ADDR_LEN_DEF = 10;

    // Layer lengths in bits, shared with the compute engine
    localparam int LEN_W1 = 802816;
    localparam int LEN_W2 = 1048576;
    localparam int LEN_W3 = 1048576;
    localparam int LEN_W4 = 10240;
    localparam int LEN_X1 = 784;

    localparam logic [2:0] SEG_W1 = 3'd0;
    localparam logic [2:0] SEG_W2 = 3'd1;
    localparam logic [2:0] SEG_W3 = 3'd2;
    localparam logic [2:0] SEG_W4 = 3'd3;
    localparam logic [2:0] SEG_X1 = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCEPT  = 3'd1,
        ST_PRESET  = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FINISH  = 3'd4,
        ST_ADVANCE = 3'd5,
        ST_RUN     = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bnn_mem_loader_if.sv
`default_nettype none
// ============================================================================
// bnn_mem_loader_if : bit stream handshake plus W/X bank write buses
// Revision: 1.0
// ============================================================================
interface bnn_mem_loader_if
    import bnn_pkg::*;
#(
    parameter int W_ADDR_LEN = W_ADDR_LEN_DEF,
    parameter int X_ADDR_LEN = X_ADDR_LEN_DEF
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_bit;

    logic [W_ADDR_LEN-1:0] w_addr;
    logic [1:0]            w_sel;
    logic                  w_wdata;
    logic                  w_wq;

    logic [X_ADDR_LEN-1:0] x_addr;
    logic [1:0]            x_sel;
    logic                  x_wdata;
    logic                  x_wq;

    // master = the loader; slave = stream source and memory banks
    modport master (
        input  in_valid, in_bit,
        output in_ready,
        output w_addr, w_sel, w_wdata, w_wq,
        output x_addr, x_sel, x_wdata, x_wq
    );

    modport slave (
        output in_valid, in_bit,
        input  in_ready,
        input  w_addr, w_sel, w_wdata, w_wq,
        input  x_addr, x_sel, x_wdata, x_wq
    );

endinterface
`default_nettype wire

// File: rtl/bnn_seg_len_rom.sv
`default_nettype none
// ============================================================================
// bnn_seg_len_rom : combinational map from segment index to its last address
// Revision: 1.0
// ============================================================================
module bnn_seg_len_rom
    import bnn_pkg::*;
#(
    parameter int W_ADDR_LEN = W_ADDR_LEN_DEF,
    parameter int W1_LEN     = LEN_W1,
    parameter int W2_LEN     = LEN_W2,
    parameter int W3_LEN     = LEN_W3,
    parameter int W4_LEN     = LEN_W4,
    parameter int X1_LEN     = LEN_X1
) (
    input  logic [2:0]            seg,
    output logic [W_ADDR_LEN-1:0] last_addr
);

    always_comb begin
        last_addr = '0;
        case (seg)
            SEG_W1:  last_addr = W_ADDR_LEN'(W1_LEN - 1);
            SEG_W2:  last_addr = W_ADDR_LEN'(W2_LEN - 1);
            SEG_W3:  last_addr = W_ADDR_LEN'(W3_LEN - 1);
            SEG_W4:  last_addr = W_ADDR_LEN'(W4_LEN - 1);
            SEG_X1:  last_addr = W_ADDR_LEN'(X1_LEN - 1);
            default: last_addr = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bnn_mem_loader.sv
`default_nettype none
// ============================================================================
// bnn_mem_loader : streams bits into W1..W4/X1 banks, then runs the compute engine
// Revision: 1.0
// ============================================================================
module bnn_mem_loader
    import bnn_pkg::*;
#(
    parameter int W_ADDR_LEN = W_ADDR_LEN_DEF,
    parameter int X_ADDR_LEN = X_ADDR_LEN_DEF,
    parameter int W1_LEN     = LEN_W1,
    parameter int W2_LEN     = LEN_W2,
    parameter int W3_LEN     = LEN_W3,
    parameter int W4_LEN     = LEN_W4,
    parameter int X1_LEN     = LEN_X1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    bnn_mem_loader_if.master  bus,
    output logic              mem_grant,
    output logic              compute_en,
    input  logic              compute_finish,
    input  logic [3:0]        result_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        result
);

    state_t                state, state_nxt;
    logic [2:0]            seg, seg_nxt;
    logic [W_ADDR_LEN-1:0] addr, addr_nxt, seg_last;

    logic                  in_ready_nxt;
    logic [W_ADDR_LEN-1:0] w_addr_nxt;
    logic [1:0]            w_sel_nxt;
    logic                  w_wdata_nxt, w_wq_nxt;
    logic [X_ADDR_LEN-1:0] x_addr_nxt;
    logic                  x_wdata_nxt, x_wq_nxt;
    logic                  compute_en_nxt, mem_grant_nxt, busy_nxt, done_nxt;
    logic [3:0]            result_nxt;

    bnn_seg_len_rom #(
        .W_ADDR_LEN (W_ADDR_LEN),
        .W1_LEN     (W1_LEN),
        .W2_LEN     (W2_LEN),
        .W3_LEN     (W3_LEN),
        .W4_LEN     (W4_LEN),
        .X1_LEN     (X1_LEN)
    ) u_seg_len_rom (
        .seg       (seg),
        .last_addr (seg_last)
    );

    assign bus.x_sel = 2'b00;

    always_comb begin
        state_nxt   = state;
        seg_nxt     = seg;
        addr_nxt    = addr;
        w_addr_nxt  = bus.w_addr;
        w_sel_nxt   = bus.w_sel;
        w_wdata_nxt = bus.w_wdata;
        x_addr_nxt  = bus.x_addr;
        x_wdata_nxt = bus.x_wdata;
        done_nxt    = done;
        result_nxt  = result;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_ACCEPT;
                    seg_nxt   = SEG_W1;
                    addr_nxt  = '0;
                    done_nxt  = 1'b0;
                end
            end
            ST_ACCEPT: begin
                // The bank bus is loaded on acceptance so it is already stable in PRESET
                if (bus.in_valid) begin
                    state_nxt = ST_PRESET;
                    if (seg == SEG_X1) begin
                        x_addr_nxt  = addr[X_ADDR_LEN-1:0];
                        x_wdata_nxt = bus.in_bit;
                    end else begin
                        w_addr_nxt  = addr;
                        w_sel_nxt   = seg[1:0];
                        w_wdata_nxt = bus.in_bit;
                    end
                end
            end
            ST_PRESET: state_nxt = ST_WRITE;
            ST_WRITE:  state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_ADVANCE;
            ST_ADVANCE: begin
                if (addr == seg_last) begin
                    addr_nxt  = '0;
                    seg_nxt   = seg + 3'd1;
                    state_nxt = (seg == SEG_X1) ? ST_RUN : ST_ACCEPT;
                end else begin
                    addr_nxt  = addr + 1'b1;
                    state_nxt = ST_ACCEPT;
                end
            end
            ST_RUN: begin
                if (compute_finish) begin
                    result_nxt = result_in;
                    done_nxt   = 1'b1;
                    state_nxt  = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so every port comes straight from a flop
        in_ready_nxt   = (state_nxt == ST_ACCEPT);
        w_wq_nxt       = (state_nxt == ST_WRITE) && (seg != SEG_X1);
        x_wq_nxt       = (state_nxt == ST_WRITE) && (seg == SEG_X1);
        compute_en_nxt = (state_nxt == ST_RUN);
        mem_grant_nxt  = (state_nxt != ST_RUN);
        busy_nxt       = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            seg         <= '0;
            addr        <= '0;
            bus.in_ready <= 1'b0;
            bus.w_addr  <= '0;
            bus.w_sel   <= '0;
            bus.w_wdata <= 1'b0;
            bus.w_wq    <= 1'b0;
            bus.x_addr  <= '0;
            bus.x_wdata <= 1'b0;
            bus.x_wq    <= 1'b0;
            compute_en  <= 1'b0;
            mem_grant   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
        end else begin
            state       <= state_nxt;
            seg         <= seg_nxt;
            addr        <= addr_nxt;
            bus.in_ready <= in_ready_nxt;
            bus.w_addr  <= w_addr_nxt;
            bus.w_sel   <= w_sel_nxt;
            bus.w_wdata <= w_wdata_nxt;
            bus.w_wq    <= w_wq_nxt;
            bus.x_addr  <= x_addr_nxt;
            bus.x_wdata <= x_wdata_nxt;
            bus.x_wq    <= x_wq_nxt;
            compute_en  <= compute_en_nxt;
            mem_grant   <= mem_grant_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            result      <= result_nxt;
        end
    end

endmodule
`default_nettype wire
